mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, data RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter RD_LAT, default 1, legal 1..4, data RAM read latency in clk cycles.
REQ-004 SHALL have parameter MEM_DEPTH, default 4096, number of implemented RAM words.
REQ-005 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: req_valid in 1 request present; req_ready out 1 request accepted; req_write in 1 1=store, 0=load; req_addr in ADDR_W word address; req_wdata in DATA_W store data.
REQ-008 SHALL have ports: resp_valid out 1 response present; resp_ready in 1 consumer takes response; resp_rdata out DATA_W load data; resp_fault out 1 access rejected.
REQ-009 SHALL have ports toward data_ram: mem_address out ADDR_W; mem_write_data out DATA_W; mem_read_not_write out 1; mem_cs out 1; mem_read_data in DATA_W.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP.
REQ-011 SHALL assert req_ready only in IDLE; handshake occurs on an edge with req_valid=1 and req_ready=1.
REQ-012 SHALL register req_write, req_addr, req_wdata at handshake and move IDLE->ACCESS.
REQ-013 SHALL drive mem_cs=1 for exactly one cycle, in ACCESS only, with mem_address/mem_write_data from the registered request and mem_read_not_write=~req_write.
REQ-014 SHALL hold mem_cs=0 and mem_read_not_write=1 in every state other than ACCESS; mem_address/mem_write_data hold last registered values.
REQ-015 SHALL, for a store, move ACCESS->RESP; resp_valid first high 2 cycles after the handshake edge.
REQ-016 SHALL, for a load, move ACCESS->WAIT, remain in WAIT RD_LAT cycles (2-bit down-counter), capture mem_read_data into resp_rdata at the edge leaving WAIT, then RESP; resp_valid first high RD_LAT+2 cycles after handshake.
REQ-017 SHALL hold resp_valid, resp_rdata, resp_fault stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-018 SHALL leave resp_rdata unchanged by stores; resp_fault=0 for every accepted in-range access.
REQ-019 SHALL ignore req_valid and all req_* inputs outside IDLE; no request queueing (one outstanding access).
REQ-020 SHALL not accept a new request in the same cycle as a RESP->IDLE transition (minimum 1 idle cycle between accesses).

Reset
REQ-021 SHALL, on rst=1, immediately enter IDLE and set req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_cs=0, mem_read_not_write=1, mem_address=0, mem_write_data=0, counter=0.
REQ-022 SHALL abandon any in-flight access on rst; no later response for it is ever produced.

Configuration
REQ-023 SHALL honour macro MEM_ADDR_CHECK_EN: when defined, an accepted request with req_addr >= MEM_DEPTH skips ACCESS/WAIT (mem_cs stays 0), goes directly IDLE->RESP with resp_fault=1, resp_rdata unchanged; response 1 cycle after handshake.
REQ-024 SHALL, without MEM_ADDR_CHECK_EN, tie resp_fault to 0 and pass every address to the RAM unchecked.

Structure
REQ-025 SHALL place FSM state enum, ADDR_W/DATA_W defaults and RD_LAT limit in shared package mem_pkg, reused by data_ram and the datapath.
REQ-026 SHALL be a single module with no sub-modules; data_ram is instantiated only by the parent.

Verification
REQ-027 Store 0xBEEF to 0x010, resp_ready=1 -> mem_cs high one cycle with read_not_write=0, address 0x010; resp_valid 2 cycles after handshake; fault=0.
REQ-028 Load 0x010 after REQ-027 with RD_LAT=1 -> resp_valid 3 cycles after handshake, resp_rdata=0xBEEF; repeat with RD_LAT=3 -> 5 cycles.
REQ-029 Load with resp_ready held 0 for 4 cycles -> resp_valid and resp_rdata=0xBEEF stable all 4 cycles; IDLE after ready edge; req_valid toggling during this is ignored.
REQ-030 rst asserted mid-WAIT of a load -> next cycle resp_valid=0, mem_cs=0, req_ready=1, resp_rdata=0; no response appears later.
REQ-031 With MEM_ADDR_CHECK_EN and MEM_DEPTH=2048, load 0x800 -> mem_cs never asserted, resp_valid 1 cycle after handshake, resp_fault=1; without macro same load reaches RAM, fault=0.
REQ-032 Back-to-back requests with req_valid held 1 -> each access separated by one IDLE cycle; 0x000 and 0xFFF addresses driven unmodified.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM states and default geometry for the memory access controller, data_ram and datapath
package mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;
  localparam int RD_LAT_MAX = 4;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer in front of a fixed-latency data RAM
// Optional MEM_ADDR_CHECK_EN faults requests at or above MEM_DEPTH without touching the RAM.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = 1,
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read_not_write,
  output logic              mem_cs,
  input  logic [DATA_W-1:0] mem_read_data
);
`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  state_t state, nxt;
  logic wr, fault, bad;
  logic [1:0] cnt;
  assign bad = CHECK && (32'(req_addr) >= 32'(MEM_DEPTH));
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? (bad ? RESP : ACCESS) : IDLE;
      ACCESS:  nxt = wr ? RESP : WAIT;
      WAIT:    nxt = (cnt == 2'd0) ? RESP : WAIT;
      default: nxt = resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr             <= 1'b0;
      fault          <= 1'b0;
      cnt            <= 2'd0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_rdata     <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        wr             <= req_write;
        fault          <= bad;
        mem_address    <= req_addr;
        mem_write_data <= req_wdata;
      end
      if (state == ACCESS) cnt <= 2'(RD_LAT - 1);
      else if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
      if (state == WAIT && cnt == 2'd0) resp_rdata <= mem_read_data;
    end
  end
  assign req_ready          = state == IDLE;
  assign resp_valid         = state == RESP;
  assign resp_fault         = fault;
  assign mem_cs             = state == ACCESS;
  assign mem_read_not_write = !(mem_cs && wr);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: two controllers (RD_LAT 1 and 3, MEM_DEPTH 2048) each behind a bench RAM, checked against a transaction model
module tb_mem_access_ctrl;
`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, clr = 1'b1;
  logic rv[2], rw[2], rr[2], rq[2], vo[2], fo[2], mcs[2], mrnw[2];
  logic [11:0] ra[2], ma[2];
  logic [15:0] rd[2], ro[2], mwd[2], mrd[2];
  logic [15:0] ram[2][4096];
  logic [15:0] pipe[2][4];
  logic [15:0] ref_mem[2][4096];
  logic [15:0] prev[2];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = g ? 3 : 1;
    mem_access_ctrl #(.ADDR_W(12), .DATA_W(16), .RD_LAT(L), .MEM_DEPTH(2048)) dut (
      .clk(clk), .rst(rst), .req_valid(rv[g]), .req_ready(rq[g]), .req_write(rw[g]),
      .req_addr(ra[g]), .req_wdata(rd[g]), .resp_valid(vo[g]), .resp_ready(rr[g]),
      .resp_rdata(ro[g]), .resp_fault(fo[g]), .mem_address(ma[g]), .mem_write_data(mwd[g]),
      .mem_read_not_write(mrnw[g]), .mem_cs(mcs[g]), .mem_read_data(mrd[g]));
    assign mrd[g] = pipe[g][L-1];
  end
  // RAM: registered read, result reaches the output port RD_LAT edges after the select edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) for (int i = 0; i < 4096; i++) ram[k][i] <= '0;
      else if (mcs[k] && !mrnw[k]) ram[k][ma[k]] <= mwd[k];
      pipe[k][0] <= (mcs[k] && mrnw[k]) ? ram[k][ma[k]] : pipe[k][0];
      for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic scramble(input int k);
    rv[k] = 1'($urandom); rw[k] = 1'($urandom); ra[k] = 12'($urandom); rd[k] = 16'($urandom);
  endtask
  function automatic bit is_oob(input logic [11:0] a);
    return CHK && a >= 12'h800;
  endfunction
  task automatic apply(input int k, input bit w, input logic [11:0] a, input logic [15:0] d);
    if (!is_oob(a)) begin
      if (w) ref_mem[k][a] = d;
      else prev[k] = ref_mem[k][a];
    end
  endtask
  task automatic do_txn(input int k, input bit w, input logic [11:0] a, input logic [15:0] d,
                        input int hold, input int elat, input logic [15:0] erd, input bit ef);
    int n, cs;
    logic [11:0] csa;
    logic [15:0] cswd;
    logic csrnw;
    csa = '0; cswd = '0; csrnw = 1'b0;
    @(negedge clk);
    n = 0;
    while (!rq[k] && n < 20) begin @(negedge clk); n++; end
    check("req_ready_before", 32'(rq[k]), 1);
    rv[k] = 1'b1; rw[k] = w; ra[k] = a; rd[k] = d; rr[k] = 1'b0;
    @(posedge clk); #1;
    scramble(k);
    n = 1; cs = 0;
    @(negedge clk);
    while (!vo[k] && n < 20) begin
      if (mcs[k]) begin cs++; csa = ma[k]; cswd = mwd[k]; csrnw = mrnw[k]; end
      scramble(k);
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(elat));
    check("cs_pulses", 32'(cs), ef ? 0 : 1);
    if (cs == 1) begin
      check("cs_addr", 32'(csa), 32'(a));
      check("cs_rnw", 32'(csrnw), 32'(!w));
      if (w) check("cs_wdata", 32'(cswd), 32'(d));
    end
    check("fault", 32'(fo[k]), 32'(ef));
    check("rdata", 32'(ro[k]), 32'(erd));
    for (int i = 0; i < hold; i++) begin
      scramble(k);
      @(negedge clk);
      check("hold_valid", 32'(vo[k]), 1);
      check("hold_rdata", 32'(ro[k]), 32'(erd));
      check("hold_fault", 32'(fo[k]), 32'(ef));
    end
    rv[k] = 1'b0; rr[k] = 1'b1;
    @(negedge clk);
    check("idle_after_ready", 32'({rq[k], vo[k]}), 32'b10);
    rr[k] = 1'b0;
  endtask
  typedef struct {
    int k; bit w; logic [11:0] a; logic [15:0] d; int hold; int lat; logic [15:0] erd;
  } vec_t;
  vec_t tv[10];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 2; k++) begin
      rv[k] = 0; rw[k] = 0; ra[k] = 0; rd[k] = 0; rr[k] = 0; prev[k] = 0;
      for (int i = 0; i < 4096; i++) ref_mem[k][i] = '0;
    end
    tv[0] = '{0, 1, 12'h010, 16'hBEEF, 0, 2, 16'h0000};
    tv[1] = '{0, 0, 12'h010, 16'h0000, 0, 3, 16'hBEEF};
    tv[2] = '{1, 1, 12'h010, 16'hBEEF, 0, 2, 16'h0000};
    tv[3] = '{1, 0, 12'h010, 16'h0000, 0, 5, 16'hBEEF};
    tv[4] = '{0, 0, 12'h010, 16'h0000, 4, 3, 16'hBEEF};
    tv[5] = '{0, 1, 12'h123, 16'h1234, 1, 2, 16'hBEEF};
    tv[6] = '{0, 0, 12'h123, 16'h0000, 0, 3, 16'h1234};
    tv[7] = '{1, 0, 12'h800, 16'h0000, 2, CHK ? 1 : 5, CHK ? 16'hBEEF : 16'h0000};
    tv[8] = '{0, 0, 12'h800, 16'h0000, 2, CHK ? 1 : 3, CHK ? 16'h1234 : 16'h0000};
    tv[9] = '{1, 1, 12'hFFF, 16'h5A5A, 0, CHK ? 1 : 2, CHK ? 16'hBEEF : 16'h0000};
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(rq[k]), 1);
      check("rst_resp", 32'({vo[k], fo[k], ro[k]}), 0);
      check("rst_mem_ctl", 32'({mcs[k], mrnw[k]}), 32'b01);
      check("rst_mem_bus", 32'({ma[k], mwd[k]}), 0);
    end
    rst = 1'b0; clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_txn(tv[i].k, tv[i].w, tv[i].a, tv[i].d, tv[i].hold, tv[i].lat, tv[i].erd, is_oob(tv[i].a));
      apply(tv[i].k, tv[i].w, tv[i].a, tv[i].d);
    end
    for (int i = 0; i < 60; i++) begin
      int k, hold, lat;
      bit w, f;
      logic [11:0] a;
      logic [15:0] d;
      k = int'($urandom_range(0, 1));
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      d = 16'($urandom);
      hold = int'($urandom_range(0, 3));
      f = is_oob(a);
      lat = f ? 1 : w ? 2 : (k ? 3 : 1) + 2;
      do_txn(k, w, a, d, hold, lat, (f || w) ? prev[k] : ref_mem[k][a], f);
      apply(k, w, a, d);
    end
    begin
      int last, pend_per, ready_seen;
      logic [11:0] pend_a;
      logic [15:0] pend_d;
      last = -1; pend_per = 0; ready_seen = 0; pend_a = '0; pend_d = '0;
      @(negedge clk);
      rw[0] = 1'b1; rr[0] = 1'b1;
      for (int t = 0; t < 60 && ready_seen < 12; t++) begin
        if (mcs[0]) begin
          check("b2b_addr", 32'(ma[0]), 32'(pend_a));
          check("b2b_wdata", 32'(mwd[0]), 32'(pend_d));
        end
        if (rq[0]) begin
          if (last >= 0) check("b2b_gap", 32'(t - last), 32'(pend_per));
          last = t;
          ready_seen++;
          pend_a = ready_seen[0] ? 12'h000 : 12'hFFF;
          pend_d = 16'($urandom);
          pend_per = is_oob(pend_a) ? 2 : 3;
          rv[0] = ready_seen < 12; ra[0] = pend_a; rd[0] = pend_d;
          if (ready_seen < 12) apply(0, 1'b1, pend_a, pend_d);
        end
        @(negedge clk);
      end
      check("b2b_count", 32'(ready_seen), 12);
      rv[0] = 1'b0; rr[0] = 1'b0;
    end
    begin
      int late;
      do_txn(1, 1'b1, 12'h020, 16'hC0DE, 0, 2, prev[1], 1'b0);
      apply(1, 1'b1, 12'h020, 16'hC0DE);
      do_txn(1, 1'b0, 12'h020, 16'h0000, 0, 5, 16'hC0DE, 1'b0);
      apply(1, 1'b0, 12'h020, 16'h0000);
      @(negedge clk);
      rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 12'h010;
      @(posedge clk); @(posedge clk); @(posedge clk);
      @(negedge clk);
      rv[1] = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_wait_valid", 32'(vo[1]), 0);
      check("rst_wait_cs", 32'(mcs[1]), 0);
      check("rst_wait_ready", 32'(rq[1]), 1);
      check("rst_wait_rdata", 32'(ro[1]), 0);
      @(negedge clk);
      rst = 1'b0;
      late = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (vo[1] || mcs[1]) late++;
      end
      check("no_late_resp", 32'(late), 0);
      prev[0] = '0; prev[1] = '0;
      do_txn(0, 1'b0, 12'h010, 16'h0000, 1, 3, ref_mem[0][12'h010], 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
